// File: rtl/stump_alu_mul_seq.sv
// Sequential 16x16 unsigned multiplier (shift-and-add). All additions and
// doublings go through the external Stump ALU. This block has no adder.
module stump_alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        ready,
  output logic        done,
  output logic [15:0] product,
  output logic        overflow,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_func,
  output logic        alu_cin,
  output logic        alu_csh,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flags
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ADD, S_DBL, S_DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] acc, mcand, mplier;
  logic        ovf;

  // Only the carry flag matters; N, Z and V are ignored.
  logic unused_flags;
  assign unused_flags = ^alu_flags[3:1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: begin
        if (mplier == '0)   state_nx = S_DONE;
        else if (mplier[0]) state_nx = S_ADD;
        else                state_nx = S_DBL;
      end
      S_ADD:   state_nx = S_DBL;
      S_DBL:   state_nx = S_CHECK;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath registers: load on accepted start, update from the ALU in ADD/DBL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          acc    <= '0;
          mcand  <= op_a;
          mplier <= op_b;
          ovf    <= 1'b0;
        end
        S_ADD: begin
          acc <= alu_result;
          if (alu_flags[0]) ovf <= 1'b1;
        end
        S_DBL: begin
          mcand  <= alu_result;
          mplier <= mplier >> 1;
          // A carry off the doubled multiplicand only matters if more
          // multiplier bits are still waiting to use it.
          if (alu_flags[0] && (mplier[15:1] != '0)) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registers only
  always_comb begin
    ready    = (state == S_IDLE);
    done     = (state == S_DONE);
    product  = acc;
    overflow = ovf;
    alu_a    = (state == S_DBL) ? mcand : acc;
    alu_b    = mcand;
    alu_func = 3'b000;
    alu_cin  = 1'b0;
    alu_csh  = 1'b0;
  end

endmodule
